// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state encoding and the 3-sample majority helper.
package uart_pkg;

   localparam int OVERSAMPLE = 16;
   localparam int OS_W       = $clog2(OVERSAMPLE);
   localparam int SAMPLE_T0  = 7;
   localparam int SAMPLE_T1  = 8;
   localparam int SAMPLE_T2  = 9;
   localparam int LAST_TICK  = 15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK_WAIT
   } uart_state_e;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock tick every div+1 clocks while enabled; no backpressure.
// Latency: first tick div+1 clocks after clr drops; clr holds the counter at zero.
module uart_baud_tick #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 clr,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

   assign tick = en && !clr && (cnt_q == div);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || tick) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop sync, 16x oversample, 8N1/8E1/8O1 framing; byte lands 1 clk after stop mid-sample.
// Single holding register on valid/ready; a byte arriving while it is full is dropped and flags overrun.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS = 8,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx_in,
   input  logic [DIV_WIDTH-1:0] divisor,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 err_frame,
   output logic                 err_parity,
   output logic                 err_overrun,
   input  logic                 clr_overrun,
   output logic                 break_det,
   output logic                 busy
);

   localparam int BC_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   uart_state_e state_q, state_d;

   logic                 sync1_q, sync2_q;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
   logic                 s7_q, s7_d, s8_q, s8_d;
   logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 load_q, load_d;
   logic                 stop_q, stop_d;
   logic                 break_q, break_d;
   logic                 out_valid_q, out_valid_d;
   logic [DATA_BITS-1:0] out_data_q, out_data_d;
   logic                 err_frame_q, err_frame_d;
   logic                 err_parity_q, err_parity_d;
   logic                 err_overrun_q, err_overrun_d;

   logic rx_s, tick, mid_tick, bnd_tick, maj;

   assign rx_s = sync2_q;

   uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
      .clk   (clk),
      .reset (reset),
      .en    (1'b1),
      .clr   (state_q == ST_IDLE),
      .div   (div_q),
      .tick  (tick)
   );

   // Majority is resolved on tick 9 using the two earlier stored samples plus the live one.
   assign mid_tick = tick && (os_cnt_q == OS_W'(SAMPLE_T2));
   assign bnd_tick = tick && (os_cnt_q == OS_W'(LAST_TICK));
   assign maj      = majority3(s7_q, s8_q, rx_s);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:       if (!rx_s) state_d = ST_START;
         ST_START: begin
            if (mid_tick && maj)  state_d = ST_IDLE;
            else if (bnd_tick)    state_d = ST_DATA;
         end
         ST_DATA: begin
            if (bnd_tick && (bit_cnt_q == BC_W'(DATA_BITS - 1)))
               state_d = parity_en ? ST_PARITY : ST_STOP;
         end
         ST_PARITY:     if (bnd_tick) state_d = ST_STOP;
         ST_STOP: begin
            if (mid_tick)
               state_d = (!maj && (shift_q == '0)) ? ST_BREAK_WAIT : ST_IDLE;
         end
         ST_BREAK_WAIT: if (rx_s) state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      div_d         = div_q;
      os_cnt_d      = os_cnt_q;
      s7_d          = s7_q;
      s8_d          = s8_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      perr_d        = perr_q;
      load_d        = 1'b0;
      stop_d        = stop_q;
      break_d       = 1'b0;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      err_frame_d   = err_frame_q;
      err_parity_d  = err_parity_q;
      err_overrun_d = err_overrun_q;

      if (state_q == ST_IDLE) begin
         os_cnt_d = '0;
         if (!rx_s) begin
            div_d     = divisor;
            bit_cnt_d = '0;
            perr_d    = 1'b0;
         end
      end else if (tick) begin
         os_cnt_d = bnd_tick ? '0 : os_cnt_q + 1'b1;
         if (os_cnt_q == OS_W'(SAMPLE_T0)) s7_d = rx_s;
         if (os_cnt_q == OS_W'(SAMPLE_T1)) s8_d = rx_s;
      end

      if (state_q == ST_DATA) begin
         if (mid_tick) shift_d = {maj, shift_q[DATA_BITS-1:1]};
         if (bnd_tick) bit_cnt_d = bit_cnt_q + 1'b1;
      end
      if (state_q == ST_PARITY && mid_tick) begin
         perr_d = maj != (^shift_q ^ parity_odd);
      end
      if (state_q == ST_STOP && mid_tick) begin
         load_d  = 1'b1;
         stop_d  = maj;
         break_d = !maj && (shift_q == '0);
      end

      if (clr_overrun) err_overrun_d = 1'b0;
      if (load_q) begin
         if (!out_valid_q || out_ready) begin
            out_valid_d  = 1'b1;
            out_data_d   = shift_q;
            err_frame_d  = !stop_q;
            err_parity_d = perr_q;
         end else begin
            err_overrun_d = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         div_q         <= '0;
         os_cnt_q      <= '0;
         s7_q          <= 1'b1;
         s8_q          <= 1'b1;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         perr_q        <= 1'b0;
         load_q        <= 1'b0;
         stop_q        <= 1'b1;
         break_q       <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         err_frame_q   <= 1'b0;
         err_parity_q  <= 1'b0;
         err_overrun_q <= 1'b0;
      end else begin
         sync1_q       <= rx_in;
         sync2_q       <= sync1_q;
         div_q         <= div_d;
         os_cnt_q      <= os_cnt_d;
         s7_q          <= s7_d;
         s8_q          <= s8_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         perr_q        <= perr_d;
         load_q        <= load_d;
         stop_q        <= stop_d;
         break_q       <= break_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         err_frame_q   <= err_frame_d;
         err_parity_q  <= err_parity_d;
         err_overrun_q <= err_overrun_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign err_frame   = err_frame_q;
   assign err_parity  = err_parity_q;
   assign err_overrun = err_overrun_q;
   assign break_det   = break_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: divisor=3 gives 64 clocks per bit.
module tb_uart_rx_core;

   localparam int BIT_CLKS = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_in;
   logic [15:0] divisor;
   logic        parity_en;
   logic        parity_odd;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        err_frame;
   logic        err_parity;
   logic        err_overrun;
   logic        clr_overrun;
   logic        break_det;
   logic        busy;

   int   total = 0;
   int   bad = 0;
   int   brk_cnt = 0;
   int   vld_cnt = 0;
   logic vld_prev = 1'b0;
   int   base;

   uart_rx_core dut (
      .clk         (clk),
      .reset       (reset),
      .rx_in       (rx_in),
      .divisor     (divisor),
      .parity_en   (parity_en),
      .parity_odd  (parity_odd),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .err_frame   (err_frame),
      .err_parity  (err_parity),
      .err_overrun (err_overrun),
      .clr_overrun (clr_overrun),
      .break_det   (break_det),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Pulse counters: break_det pulses and out_valid rising edges.
   always @(negedge clk) begin
      if (break_det === 1'b1) brk_cnt++;
      if (out_valid === 1'b1 && vld_prev !== 1'b1) vld_cnt++;
      vld_prev = out_valid;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic v);
      rx_in = v;
      idle(BIT_CLKS);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic pbit, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (par) send_bit(pbit);
      send_bit(stop);
      rx_in = 1'b1;
      idle(2 * BIT_CLKS);
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("consume_vld", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      reset = 1'b1; rx_in = 1'b1; divisor = 16'd3;
      parity_en = 1'b0; parity_odd = 1'b0; out_ready = 1'b0; clr_overrun = 1'b0;
      idle(5);
      reset = 1'b0;
      idle(2);
      chk("rst_vld",   {31'd0, out_valid},   32'd0);
      chk("rst_data",  {24'd0, out_data},    32'd0);
      chk("rst_ferr",  {31'd0, err_frame},   32'd0);
      chk("rst_ovr",   {31'd0, err_overrun}, 32'd0);
      chk("rst_busy",  {31'd0, busy},        32'd0);
      chk("rst_brk",   {31'd0, break_det},   32'd0);

      // Clean 8N1 byte
      base = vld_cnt;
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      chk("a5_vld",   {31'd0, out_valid},  32'd1);
      chk("a5_data",  {24'd0, out_data},   32'hA5);
      chk("a5_ferr",  {31'd0, err_frame},  32'd0);
      chk("a5_perr",  {31'd0, err_parity}, 32'd0);
      chk("a5_count", vld_cnt - base,      32'd1);
      consume();

      // False start: glitch shorter than half a bit
      base = vld_cnt;
      rx_in = 1'b0;
      idle(20);
      chk("fs_busy_hi", {31'd0, busy}, 32'd1);
      rx_in = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (busy === 1'b0) break;
         @(negedge clk);
      end
      chk("fs_busy_lo", {31'd0, busy}, 32'd0);
      idle(2 * BIT_CLKS);
      chk("fs_no_vld", vld_cnt - base, 32'd0);

      // Framing error, non-zero data: no break
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      chk("fe_data", {24'd0, out_data},  32'h3C);
      chk("fe_ferr", {31'd0, err_frame}, 32'd1);
      chk("fe_brk",  brk_cnt,            32'd0);
      consume();

      // Break: line low for 12 bit times
      rx_in = 1'b0;
      idle(12 * BIT_CLKS);
      rx_in = 1'b1;
      idle(2 * BIT_CLKS);
      chk("brk_vld",  {31'd0, out_valid}, 32'd1);
      chk("brk_data", {24'd0, out_data},  32'h00);
      chk("brk_ferr", {31'd0, err_frame}, 32'd1);
      chk("brk_cnt",  brk_cnt,            32'd1);
      chk("brk_busy", {31'd0, busy},      32'd0);
      consume();
      send_frame(8'h55, 1'b0, 1'b0, 1'b1);
      chk("post_brk_data", {24'd0, out_data},  32'h55);
      chk("post_brk_ferr", {31'd0, err_frame}, 32'd0);
      chk("post_brk_cnt",  brk_cnt,            32'd1);
      consume();

      // Overrun: second byte dropped while holding register is full
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      chk("ovr_none", {31'd0, err_overrun}, 32'd0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      chk("ovr_data", {24'd0, out_data},    32'h11);
      chk("ovr_vld",  {31'd0, out_valid},   32'd1);
      chk("ovr_set",  {31'd0, err_overrun}, 32'd1);
      clr_overrun = 1'b1;
      @(negedge clk);
      clr_overrun = 1'b0;
      chk("ovr_clr",  {31'd0, err_overrun}, 32'd0);
      chk("ovr_keep", {24'd0, out_data},    32'h11);
      consume();

      // Odd parity on 0x03: correct parity bit is 1
      parity_en = 1'b1; parity_odd = 1'b1;
      send_frame(8'h03, 1'b1, 1'b0, 1'b1);
      chk("par_bad_data", {24'd0, out_data},   32'h03);
      chk("par_bad_perr", {31'd0, err_parity}, 32'd1);
      chk("par_bad_ferr", {31'd0, err_frame},  32'd0);
      consume();
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      chk("par_ok_data", {24'd0, out_data},   32'h03);
      chk("par_ok_perr", {31'd0, err_parity}, 32'd0);
      consume();
      parity_en = 1'b0; parity_odd = 1'b0;

      // Reset mid-frame with a byte parked in the holding register
      send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
      chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
      fork
         send_frame(8'h77, 1'b0, 1'b0, 1'b1);
         begin
            idle(300);
            chk("mid_busy", {31'd0, busy}, 32'd1);
            reset = 1'b1;
            @(negedge clk);
            chk("mid_rst_busy", {31'd0, busy},      32'd0);
            chk("mid_rst_vld",  {31'd0, out_valid}, 32'd0);
         end
      join
      reset = 1'b0;
      idle(4);
      chk("post_rst_vld",  {31'd0, out_valid}, 32'd0);
      chk("post_rst_busy", {31'd0, busy},      32'd0);
      send_frame(8'h81, 1'b0, 1'b0, 1'b1);
      chk("r81_vld",  {31'd0, out_valid}, 32'd1);
      chk("r81_data", {24'd0, out_data},  32'h81);
      chk("r81_ferr", {31'd0, err_frame}, 32'd0);
      consume();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
